// File: rtl/tlb_gen2.sv
// Fully associative Sv39 TLB with tree-PLRU replacement, registered 1-cycle lookup and sfence.vma flush.
// Defining TLB_PERF_CNT_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
package riscv;
  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;
endpackage

module tlb_gen2 #(
  parameter int unsigned TLB_ENTRIES = 8,
  parameter int unsigned ASID_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  flush_asid_en_i,
  input  logic                  flush_vaddr_en_i,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  input  logic [63:0]           flush_vaddr_i,
  input  logic                  upd_valid_i,
  input  logic [26:0]           upd_vpn_i,
  input  logic [ASID_WIDTH-1:0] upd_asid_i,
  input  logic                  upd_is_2M_i,
  input  logic                  upd_is_1G_i,
  input  riscv::pte_t           upd_content_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [63:0]           lu_vaddr_i,
  output logic                  lu_valid_o,
  output logic                  lu_hit_o,
  output logic                  lu_is_2M_o,
  output logic                  lu_is_1G_o,
  output riscv::pte_t           lu_content_o
`ifdef TLB_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  localparam int unsigned LVL = $clog2(TLB_ENTRIES);
  typedef logic [LVL-1:0] idx_t;

  // An address falls in an entry's page when the VPN levels above the page size agree.
  function automatic logic vpnCovers(input logic [26:0] entVpn, input logic ent2M,
                                     input logic ent1G, input logic [26:0] vpn);
    return (entVpn[26:18] == vpn[26:18]) &&
           (ent1G || (entVpn[17:9] == vpn[17:9])) &&
           (ent1G || ent2M || (entVpn[8:0] == vpn[8:0]));
  endfunction

  logic [TLB_ENTRIES-1:0] valid_q, valid_d;
  logic [TLB_ENTRIES-1:1] plru_q, plru_d;
  logic [26:0]            vpn_q     [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0]  asid_q    [TLB_ENTRIES];
  riscv::pte_t            content_q [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] is2M_q, is1G_q;

  logic [TLB_ENTRIES-1:0] luMatch, updMatch, flushHit;
  logic [26:0]            luVpn, flVpn;
  idx_t                   luHitIdx, updHitIdx, freeIdx, plruIdx, updIdx, touchIdx, tPath;
  logic                   luHit, updWe, touchEn;
  logic [LVL:0]           node, tNode;

  logic                   luValid_q, luHit_q, lu2M_q, lu1G_q;
  riscv::pte_t            luContent_q;

  assign luVpn = lu_vaddr_i[38:12];
  assign flVpn = flush_vaddr_i[38:12];

  always_comb begin
    luMatch  = '0;
    updMatch = '0;
    flushHit = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      luMatch[i]  = valid_q[i] && (content_q[i].g || (asid_q[i] == lu_asid_i)) &&
                    vpnCovers(vpn_q[i], is2M_q[i], is1G_q[i], luVpn);
      updMatch[i] = valid_q[i] && (is2M_q[i] == upd_is_2M_i) && (is1G_q[i] == upd_is_1G_i) &&
                    (content_q[i].g || (asid_q[i] == upd_asid_i)) &&
                    vpnCovers(vpn_q[i], is2M_q[i], is1G_q[i], upd_vpn_i);
      // Each enabled qualifier narrows the flush; global entries never match an ASID flush.
      flushHit[i] = (!flush_asid_en_i || (!content_q[i].g && (asid_q[i] == flush_asid_i))) &&
                    (!flush_vaddr_en_i || vpnCovers(vpn_q[i], is2M_q[i], is1G_q[i], flVpn));
    end
  end

  always_comb begin
    luHitIdx  = '0;
    updHitIdx = '0;
    freeIdx   = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (luMatch[i])  luHitIdx  = idx_t'(i);
      if (updMatch[i]) updHitIdx = idx_t'(i);
      if (!valid_q[i]) freeIdx   = idx_t'(i);
    end
  end

  // Heap-ordered tree rooted at node 1; a node bit of 1 sends the victim search right.
  always_comb begin
    node = {{LVL{1'b0}}, 1'b1};
    for (int l = 0; l < LVL; l++) begin
      node = {node[LVL-1:0], plru_q[node[LVL-1:0]]};
    end
    plruIdx = node[LVL-1:0];
  end

  assign luHit  = |luMatch;
  assign updWe  = upd_valid_i && !flush_i;
  assign updIdx = (|updMatch) ? updHitIdx : ((~&valid_q) ? freeIdx : plruIdx);

  always_comb begin
    plru_d   = plru_q;
    touchEn  = 1'b0;
    touchIdx = '0;
    tNode    = {{LVL{1'b0}}, 1'b1};
    tPath    = '0;
    if (updWe) begin
      touchEn  = 1'b1;
      touchIdx = updIdx;
    end else if (lu_access_i && luHit) begin
      touchEn  = 1'b1;
      touchIdx = luHitIdx;
    end
    if (touchEn) begin
      tPath = touchIdx;
      for (int l = 0; l < LVL; l++) begin
        plru_d[tNode[LVL-1:0]] = ~tPath[LVL-1];
        tNode = {tNode[LVL-1:0], tPath[LVL-1]};
        tPath = tPath << 1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = valid_q & ~flushHit;
    end else if (updWe) begin
      valid_d[updIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      valid_q <= valid_d;
      plru_q  <= plru_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (updWe) begin
      vpn_q[updIdx]     <= upd_vpn_i;
      asid_q[updIdx]    <= upd_asid_i;
      is2M_q[updIdx]    <= upd_is_2M_i;
      is1G_q[updIdx]    <= upd_is_1G_i;
      content_q[updIdx] <= upd_content_i;
    end
  end

  // Response registers sample the pre-write array; they hold when no lookup was issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      luValid_q   <= 1'b0;
      luHit_q     <= 1'b0;
      lu2M_q      <= 1'b0;
      lu1G_q      <= 1'b0;
      luContent_q <= '0;
    end else begin
      luValid_q <= lu_access_i;
      if (lu_access_i) begin
        luHit_q     <= luHit;
        lu2M_q      <= luHit && is2M_q[luHitIdx];
        lu1G_q      <= luHit && is1G_q[luHitIdx];
        luContent_q <= luHit ? content_q[luHitIdx] : '0;
      end
    end
  end

  assign lu_valid_o   = luValid_q;
  assign lu_hit_o     = luHit_q;
  assign lu_is_2M_o   = lu2M_q;
  assign lu_is_1G_o   = lu1G_q;
  assign lu_content_o = luContent_q;

`ifdef TLB_PERF_CNT_EN
  logic [31:0] hitCnt_q, missCnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else if (lu_access_i) begin
      if (luHit && (hitCnt_q != 32'hFFFF_FFFF))   hitCnt_q  <= hitCnt_q + 32'd1;
      if (!luHit && (missCnt_q != 32'hFFFF_FFFF)) missCnt_q <= missCnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hitCnt_q;
  assign miss_cnt_o = missCnt_q;
`endif

  logic unusedBits;
  assign unusedBits = ^{lu_vaddr_i[63:39], lu_vaddr_i[11:0], flush_vaddr_i[63:39],
                        flush_vaddr_i[11:0], node[LVL], tNode[LVL]};

  // Overlapping entries for one lookup indicate a broken refill sequence.
  assert property (@(posedge clk_i) disable iff (!rst_ni) lu_access_i |-> $onehot0(luMatch));

endmodule

// File: tb/tb_tlb_gen2.sv
// Bench for tlb_gen2: directed scenarios, then random traffic checked against a timestamp/page-range TLB model.
// Build with +define+TLB_PERF_CNT_EN to also exercise the hit/miss counters.
module tb_tlb_gen2;
  localparam int N  = 8;
  localparam int AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i, flush_asid_en_i, flush_vaddr_en_i;
  logic [AW-1:0] flush_asid_i;
  logic [63:0]   flush_vaddr_i;
  logic          upd_valid_i;
  logic [26:0]   upd_vpn_i;
  logic [AW-1:0] upd_asid_i;
  logic          upd_is_2M_i, upd_is_1G_i;
  riscv::pte_t   upd_content_i;
  logic          lu_access_i;
  logic [AW-1:0] lu_asid_i;
  logic [63:0]   lu_vaddr_i;
  logic          lu_valid_o, lu_hit_o, lu_is_2M_o, lu_is_1G_o;
  riscv::pte_t   lu_content_o;
`ifdef TLB_PERF_CNT_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

  tlb_gen2 #(.TLB_ENTRIES(N), .ASID_WIDTH(AW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .flush_asid_en_i  (flush_asid_en_i),
    .flush_vaddr_en_i (flush_vaddr_en_i),
    .flush_asid_i     (flush_asid_i),
    .flush_vaddr_i    (flush_vaddr_i),
    .upd_valid_i      (upd_valid_i),
    .upd_vpn_i        (upd_vpn_i),
    .upd_asid_i       (upd_asid_i),
    .upd_is_2M_i      (upd_is_2M_i),
    .upd_is_1G_i      (upd_is_1G_i),
    .upd_content_i    (upd_content_i),
    .lu_access_i      (lu_access_i),
    .lu_asid_i        (lu_asid_i),
    .lu_vaddr_i       (lu_vaddr_i),
    .lu_valid_o       (lu_valid_o),
    .lu_hit_o         (lu_hit_o),
    .lu_is_2M_o       (lu_is_2M_o),
    .lu_is_1G_o       (lu_is_1G_o),
`ifdef TLB_PERF_CNT_EN
    .lu_content_o     (lu_content_o),
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`else
    .lu_content_o     (lu_content_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Model entry: page given by base VPN and size, recency given by the time of last use.
  typedef struct {
    bit          v;
    bit [26:0]   vpn;
    bit [AW-1:0] asid;
    bit          is2M;
    bit          is1G;
    bit [63:0]   pte;
    int unsigned lastUse;
  } entry_t;

  entry_t      model [N];
  int unsigned nowTick;
  bit          expValid, expHit, exp2M, exp1G;
  bit [63:0]   expPte;
  int unsigned expHits, expMisses;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pageShift(input bit is2M, input bit is1G);
    return is1G ? 30 : (is2M ? 21 : 12);
  endfunction

  function automatic bit pageHas(input entry_t e, input bit [38:0] va);
    int s = pageShift(e.is2M, e.is1G);
    bit [38:0] base = {e.vpn, 12'h0};
    return (va >> s) == (base >> s);
  endfunction

  // Tree PLRU seen as recency: at every split descend into the half whose newest use is older.
  function automatic int plruVictim();
    int lo = 0;
    int width = N;
    while (width > 1) begin
      int half = width / 2;
      int unsigned newestL = 0;
      int unsigned newestR = 0;
      for (int i = 0; i < half; i++) begin
        if (model[lo+i].lastUse > newestL)      newestL = model[lo+i].lastUse;
        if (model[lo+half+i].lastUse > newestR) newestR = model[lo+half+i].lastUse;
      end
      if (newestL > newestR) lo += half;
      width = half;
    end
    return lo;
  endfunction

  task automatic touch(input int i);
    nowTick++;
    model[i].lastUse = nowTick;
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      model[i].v = 0;
      model[i].lastUse = 0;
    end
    nowTick = 0;
    expValid = 0; expHit = 0; exp2M = 0; exp1G = 0; expPte = '0;
    expHits = 0; expMisses = 0;
  endtask

  function automatic logic [63:0] randPte(input bit g);
    logic [63:0] p;
    p = {$urandom, $urandom};
    p[63:54] = '0;
    p[5] = g;
    p[0] = 1'b1;
    return p;
  endfunction

  // An update is issued only if it cannot leave two entries answering the same lookup.
  function automatic bit updateSafe(input bit [26:0] vpn, input bit [AW-1:0] asid,
                                    input bit is2M, input bit is1G, input bit g);
    entry_t c;
    c.v = 1; c.vpn = vpn; c.asid = asid; c.is2M = is2M; c.is1G = is1G; c.pte = '0; c.lastUse = 0;
    for (int i = 0; i < N; i++) begin
      if (model[i].v) begin
        bit exact = (model[i].is2M == is2M) && (model[i].is1G == is1G) &&
                    (model[i].pte[5] || model[i].asid == asid) && pageHas(model[i], {vpn, 12'h0});
        bit compat = model[i].pte[5] || g || (model[i].asid == asid);
        bit overlap = compat && (pageHas(model[i], {vpn, 12'h0}) || pageHas(c, {model[i].vpn, 12'h0}));
        if (overlap && !exact) return 0;
      end
    end
    return 1;
  endfunction

  task automatic idleInputs();
    flush_i = 0; flush_asid_en_i = 0; flush_vaddr_en_i = 0; flush_asid_i = '0; flush_vaddr_i = '0;
    upd_valid_i = 0; upd_vpn_i = '0; upd_asid_i = '0; upd_is_2M_i = 0; upd_is_1G_i = 0;
    upd_content_i = '0;
    lu_access_i = 0; lu_asid_i = '0; lu_vaddr_i = '0;
  endtask

  // Predict one clock cycle from the currently driven inputs, clock it, and compare all outputs.
  task automatic applyStimulus();
    int hitIdx = -1;
    if (lu_access_i) begin
      for (int i = 0; i < N; i++)
        if (model[i].v && (model[i].pte[5] || model[i].asid == lu_asid_i) &&
            pageHas(model[i], lu_vaddr_i[38:0])) hitIdx = i;
      expValid = 1;
      expHit   = (hitIdx >= 0);
      exp2M    = expHit ? model[hitIdx].is2M : 1'b0;
      exp1G    = expHit ? model[hitIdx].is1G : 1'b0;
      expPte   = expHit ? model[hitIdx].pte  : 64'h0;
      if (expHit && expHits != 32'hFFFF_FFFF)    expHits++;
      if (!expHit && expMisses != 32'hFFFF_FFFF) expMisses++;
    end else begin
      expValid = 0;
    end
    if (flush_i) begin
      for (int i = 0; i < N; i++) begin
        bit sel = 1;
        if (flush_asid_en_i && (model[i].pte[5] || model[i].asid != flush_asid_i)) sel = 0;
        if (flush_vaddr_en_i && !pageHas(model[i], flush_vaddr_i[38:0])) sel = 0;
        if (sel) model[i].v = 0;
      end
      if (hitIdx >= 0) touch(hitIdx);
    end else if (upd_valid_i) begin
      int slot = -1;
      for (int i = 0; i < N; i++)
        if (model[i].v && model[i].is2M == upd_is_2M_i && model[i].is1G == upd_is_1G_i &&
            (model[i].pte[5] || model[i].asid == upd_asid_i) &&
            pageHas(model[i], {upd_vpn_i, 12'h0})) slot = i;
      if (slot < 0)
        for (int i = N - 1; i >= 0; i--) if (!model[i].v) slot = i;
      if (slot < 0) slot = plruVictim();
      model[slot].v    = 1;
      model[slot].vpn  = upd_vpn_i;
      model[slot].asid = upd_asid_i;
      model[slot].is2M = upd_is_2M_i;
      model[slot].is1G = upd_is_1G_i;
      model[slot].pte  = upd_content_i;
      touch(slot);
    end else if (hitIdx >= 0) begin
      touch(hitIdx);
    end
    @(posedge clk_i);
    #1;
    checkOutput("lu_valid",   lu_valid_o,   expValid);
    checkOutput("lu_hit",     lu_hit_o,     expHit);
    checkOutput("lu_is_2M",   lu_is_2M_o,   exp2M);
    checkOutput("lu_is_1G",   lu_is_1G_o,   exp1G);
    checkOutput("lu_content", lu_content_o, expPte);
`ifdef TLB_PERF_CNT_EN
    checkOutput("hit_cnt",  hit_cnt_o,  expHits);
    checkOutput("miss_cnt", miss_cnt_o, expMisses);
`endif
    idleInputs();
  endtask

  task automatic doUpdate(input bit [26:0] vpn, input bit [AW-1:0] asid,
                          input bit is2M, input bit is1G, input bit g);
    upd_valid_i = 1; upd_vpn_i = vpn; upd_asid_i = asid;
    upd_is_2M_i = is2M; upd_is_1G_i = is1G; upd_content_i = randPte(g);
    applyStimulus();
  endtask

  task automatic doLookup(input bit [63:0] va, input bit [AW-1:0] asid);
    lu_access_i = 1; lu_vaddr_i = va; lu_asid_i = asid;
    applyStimulus();
  endtask

  task automatic doFlush(input bit aEn, input bit vEn, input bit [AW-1:0] asid, input bit [63:0] va);
    flush_i = 1; flush_asid_en_i = aEn; flush_vaddr_en_i = vEn; flush_asid_i = asid; flush_vaddr_i = va;
    applyStimulus();
  endtask

  task automatic doReset();
    idleInputs();
    rst_ni = 0;
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_valid",   lu_valid_o,   1'b0);
    checkOutput("rst_hit",     lu_hit_o,     1'b0);
    checkOutput("rst_content", lu_content_o, 64'h0);
`ifdef TLB_PERF_CNT_EN
    checkOutput("rst_hit_cnt",  hit_cnt_o,  32'h0);
    checkOutput("rst_miss_cnt", miss_cnt_o, 32'h0);
`endif
    rst_ni = 1;
  endtask

  function automatic bit [63:0] vaOf(input bit [26:0] vpn);
    return {25'h0, vpn, 12'($urandom)};
  endfunction

  function automatic bit [26:0] randVpn();
    return {9'($urandom_range(0, 1)), 9'($urandom_range(0, 3)), 9'($urandom_range(0, 3))};
  endfunction

  initial begin
    rst_ni = 0;
    idleInputs();

    // 4K entry with ASID match and mismatch
    doReset();
    doUpdate(27'h1, 3, 0, 0, 0);
    doLookup(64'h1000, 3);
    checkOutput("r37_hit", lu_hit_o, 1'b1);
    doLookup(64'h1000, 4);
    checkOutput("r37_miss", lu_hit_o, 1'b0);

    // 1G global entry and ASID/global flushes
    doReset();
    doUpdate({9'd2, 18'h0}, 5, 0, 1, 1);
    doLookup(64'h8000_1234, 7);
    checkOutput("r38_1G", lu_is_1G_o, 1'b1);
    doFlush(1, 0, 7, 64'h0);
    doLookup(64'h8000_1234, 7);
    checkOutput("r38_kept", lu_hit_o, 1'b1);
    doFlush(0, 0, 0, 64'h0);
    doLookup(64'h8000_1234, 7);
    checkOutput("r38_gone", lu_hit_o, 1'b0);

    // Fill, age entry 7 to PLRU, replace it, then re-update without duplication
    doReset();
    for (int i = 0; i < N; i++) doUpdate(27'h100 + 27'(i), 1, 0, 0, 0);
    begin
      int order [7] = '{6, 4, 5, 0, 1, 2, 3};
      for (int k = 0; k < 7; k++) doLookup(vaOf(27'h100 + 27'(order[k])), 1);
    end
    doUpdate(27'h200, 1, 0, 0, 0);
    doLookup(vaOf(27'h107), 1);
    checkOutput("r39_evict7", lu_hit_o, 1'b0);
    doUpdate(27'h200, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) doLookup(vaOf(27'h100 + 27'(i)), 1);
    doLookup(vaOf(27'h200), 1);
    checkOutput("r39_new", lu_hit_o, 1'b1);

    // Superpage vaddr flush and combined ASID+vaddr flush
    doReset();
    doUpdate({9'd0, 9'd5, 9'd0}, 1, 1, 0, 0);
    doUpdate(27'h123, 2, 0, 0, 0);
    doLookup(64'h00A0_0040, 1);
    checkOutput("r40_2M", lu_is_2M_o, 1'b1);
    doFlush(0, 1, 0, 64'h00B0_3000);
    doLookup(64'h00A0_0040, 1);
    checkOutput("r40_2M_gone", lu_hit_o, 1'b0);
    doFlush(1, 1, 1, 64'h0012_3000);
    doLookup(64'h0012_3abc, 2);
    checkOutput("r40_4K_kept", lu_hit_o, 1'b1);

    // Flush wins over a simultaneous update
    flush_i = 1; upd_valid_i = 1; upd_vpn_i = 27'h300; upd_asid_i = 1; upd_content_i = randPte(0);
    applyStimulus();
    doLookup(64'h0030_0000, 1);
    checkOutput("r41_dropped", lu_hit_o, 1'b0);

    // Reset during an in-flight lookup discards it, and the next lookup misses
    doUpdate(27'h321, 1, 0, 0, 0);
    lu_access_i = 1; lu_vaddr_i = 64'h0032_1000; lu_asid_i = 1;
    @(negedge clk_i);
    rst_ni = 0;
    @(posedge clk_i);
    #1;
    checkOutput("r41_rst_valid", lu_valid_o, 1'b0);
    modelReset();
    idleInputs();
    @(posedge clk_i);
    #1;
    rst_ni = 1;
    doLookup(64'h0032_1000, 1);
    checkOutput("r34_first_miss", lu_hit_o, 1'b0);

`ifdef TLB_PERF_CNT_EN
    doReset();
    doUpdate(27'h55, 1, 0, 0, 0);
    repeat (3) doLookup(64'h0005_5000, 1);
    repeat (2) doLookup(64'h0006_6000, 1);
    checkOutput("r42_hits",   hit_cnt_o,  32'd3);
    checkOutput("r42_misses", miss_cnt_o, 32'd2);
    force dut.hitCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hitCnt_q;
    expHits = 32'hFFFF_FFFF;
    doLookup(64'h0005_5000, 1);
    checkOutput("r42_sat", hit_cnt_o, 32'hFFFF_FFFF);
`endif

    // Random mixed traffic
    doReset();
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 55 || r >= 90) begin
        lu_access_i = 1;
        lu_asid_i   = AW'($urandom_range(1, 3));
        lu_vaddr_i  = vaOf(randVpn());
      end
      if ((r >= 30 && r < 85) || r >= 95) begin
        bit [26:0]   v  = randVpn();
        bit [AW-1:0] a  = AW'($urandom_range(1, 2));
        int          sz = $urandom_range(0, 5);
        bit          g  = ($urandom_range(0, 7) == 0);
        bit          b1 = (sz == 0);
        bit          b2 = (sz == 1);
        if (updateSafe(v, a, b2, b1, g)) begin
          upd_valid_i = 1; upd_vpn_i = v; upd_asid_i = a;
          upd_is_2M_i = b2; upd_is_1G_i = b1; upd_content_i = randPte(g);
        end
      end
      if (r >= 85) begin
        flush_i          = 1;
        flush_asid_en_i  = 1'($urandom_range(0, 1));
        flush_vaddr_en_i = ($urandom_range(0, 3) != 0);
        flush_asid_i     = AW'($urandom_range(1, 3));
        flush_vaddr_i    = vaOf(randVpn());
      end
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_gen2.md
TLB_GEN2 -- requirements
Module: tlb_gen2

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 8, entry count; power of two, >= 2.
REQ-002 SHALL have parameter ASID_WIDTH, default 16, ASID bits; >= 1.
REQ-003 SHALL have port clk_i  in  1  clock; rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port flush_i  in  1  sfence.vma request, single-cycle pulse.
REQ-006 SHALL have port flush_asid_en_i  in  1  flush restricted to flush_asid_i (rs2 != x0).
REQ-007 SHALL have port flush_vaddr_en_i  in  1  flush restricted to flush_vaddr_i (rs1 != x0).
REQ-008 SHALL have port flush_asid_i  in  ASID_WIDTH  flush ASID.
REQ-009 SHALL have port flush_vaddr_i  in  64  flush virtual address.
REQ-010 SHALL have port upd_valid_i  in  1  write new translation.
REQ-011 SHALL have port upd_vpn_i  in  27  VPN[2:0] = [26:18], [17:9], [8:0].
REQ-012 SHALL have port upd_asid_i  in  ASID_WIDTH  update ASID.
REQ-013 SHALL have port upd_is_2M_i / upd_is_1G_i  in  1 each  superpage size; never both set.
REQ-014 SHALL have port upd_content_i  in  riscv::pte_t  leaf PTE; its g bit marks the entry global.
REQ-015 SHALL have port lu_access_i  in  1  lookup request.
REQ-016 SHALL have port lu_asid_i  in  ASID_WIDTH  lookup ASID.
REQ-017 SHALL have port lu_vaddr_i  in  64  lookup address; bits [38:12] are used.
REQ-018 SHALL have port lu_valid_o  out  1  registered response strobe.
REQ-019 SHALL have port lu_hit_o / lu_is_2M_o / lu_is_1G_o  out  1 each  registered hit and size.
REQ-020 SHALL have port lu_content_o  out  riscv::pte_t  registered PTE; all zero on a miss.

Function
REQ-021 Entry match SHALL require: valid; (global OR asid equal); vpn2 equal; vpn1 equal unless 1G; vpn0 equal unless 1G or 2M.
REQ-022 Lookup latency SHALL be exactly 1 cycle: lu_access_i at cycle N gives lu_valid_o=1 at N+1, with hit, size and content taken from the array state before any cycle-N write.
REQ-023 lu_valid_o SHALL be 0 in any cycle after a cycle without lu_access_i; the other outputs SHALL then hold their previous values.
REQ-024 Victim selection SHALL pick the lowest-index invalid entry if one exists, otherwise the PLRU-tree victim (TLB_ENTRIES-1 tree bits).
REQ-025 An update whose VPN, size and ASID (or global) match a valid entry SHALL overwrite that entry and allocate no second copy.
REQ-026 A lookup hit with lu_access_i, and every update write, SHALL make the touched entry MRU in the PLRU tree. When both occur in the same cycle, the update SHALL take precedence.
REQ-027 Flush SHALL invalidate entries in the cycle after flush_i, selected by the enables (asid_en, vaddr_en): (0,0) all entries; (1,0) non-global entries with asid = flush_asid_i; (0,1) entries matching flush_vaddr_i under REQ-021 with ASID ignored; (1,1) non-global entries matching both.
REQ-028 Vaddr flush SHALL honour superpages: an entry is hit if flush_vaddr_i falls anywhere inside its 4K, 2M or 1G page.
REQ-029 When flush_i and upd_valid_i occur in the same cycle, the flush SHALL apply and the update SHALL be dropped.
REQ-030 A lookup in the same cycle as a flush SHALL return the pre-flush result.
REQ-031 Flush SHALL NOT modify the PLRU tree.
REQ-032 At most one entry SHALL match any lookup; a multi-hit SHALL be flagged by a simulation-only assertion.

Reset
REQ-033 Asserting rst_ni SHALL asynchronously clear all valid bits, the PLRU tree, all outputs and all counters to 0; an in-flight lookup SHALL be discarded.
REQ-034 The first lookup after reset release SHALL miss.

Configuration
REQ-035 With TLB_PERF_CNT_EN defined, the block SHALL add outputs hit_cnt_o and miss_cnt_o (out, 32 bits each), incrementing at the same edge lu_valid_o rises for a hit or miss respectively. Each SHALL saturate at 0xFFFFFFFF and clear on reset.
REQ-036 Without TLB_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 Reset, update vpn=0x0_0001, asid=3, 4K, then lookup vaddr 0x1000 asid 3 -> lu_valid_o=1 and hit the next cycle; lookup with asid 4 -> miss.
REQ-038 Update a 1G global entry with vpn2=2, then look up 0x8000_1234 with asid 7 -> hit, lu_is_1G_o=1. Flush with (1,0) asid 7 -> entry kept; flush with (0,0) -> miss.
REQ-039 Fill 8 entries, look up entries 0..6, then update -> entry 7 replaced; a second identical update leaves 8 valid entries, with no duplicate.
REQ-040 Load 2M entry vpn2=0, vpn1=5; flush with (0,1) vaddr 0x00B0_3000 -> invalidated; a separate 4K entry at asid 2 survives a (1,1) flush with asid 1.
REQ-041 flush_i and upd_valid_i in the same cycle -> the updated VPN misses afterwards. Reset asserted one cycle after lu_access_i -> lu_valid_o stays 0.
REQ-042 With TLB_PERF_CNT_EN defined: 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2; preload 0xFFFFFFFF, then one more hit -> hit_cnt_o stays 0xFFFFFFFF.
